rgb_palette_encoder: RTL and testbench

//  Inverse of the VGA index-to-RGB palette decoder: maps a 12-bit RGB pixel to the
//  4-bit index of the nearest of the 16 palette colours. Distance is L1 (sum of |dR|,|dG|,|dB|).

---
 rtl/vga_pkg.sv | 35 +++
 rtl/rgb_palette_encoder_if.sv | 30 +++
 rtl/rgb_l1_dist.sv | 22 ++
 rtl/rgb_palette_encoder.sv | 128 ++++++++++++
 tb/tb_rgb_palette_encoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: constants, palette table and types shared by the VGA palette
// encoder (RGB -> index) and the palette decoder (index -> RGB).
//  CH_W     bits per colour channel; pixels are {R,G,B}, R in the MSBs
//  IDX_W    palette index width (2**IDX_W entries)
//  DIST_W   width of an L1 distance (max 3*(2**CH_W-1) must fit)
//  PALETTE  the one palette table both directions of the path use
//  enc_state_t  encoder FSM states
//  ch_absdiff   unsigned |a-b| of one colour channel
package vga_pkg;

    localparam int CH_W   = 4;
    localparam int IDX_W  = 4;
    localparam int DIST_W = 6;
    localparam int PIX_W  = 3 * CH_W;
    localparam int N_PAL  = 2 ** IDX_W;

    localparam logic [PIX_W-1:0] PALETTE [0:N_PAL-1] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'h000,
        12'h888, 12'h800, 12'h080, 12'h008,
        12'hF80, 12'h8F0, 12'h08F, 12'h90F
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

    function automatic logic [CH_W-1:0] ch_absdiff(input logic [CH_W-1:0] a,
                                                   input logic [CH_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/rgb_palette_encoder_if.sv
// rgb_palette_encoder_if: pixel-in / index-out streaming bus of the encoder.
//  pix_valid/pix_ready/pix_rgb        : input pixel channel
//  idx_valid/idx_ready/idx/idx_dist   : result channel
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; a producer holds valid and its payload stable until then,
// and ready may be asserted or withdrawn at any time without side effects.
//  slave  : the encoder side (consumes pixels, produces results)
//  master : the environment side (produces pixels, consumes results)
interface rgb_palette_encoder_if;
    import vga_pkg::*;

    logic                 pix_valid;
    logic                 pix_ready;
    logic [PIX_W-1:0]     pix_rgb;
    logic                 idx_valid;
    logic                 idx_ready;
    logic [IDX_W-1:0]     idx;
    logic [DIST_W-1:0]    idx_dist;

    modport slave (
        input  pix_valid, pix_rgb, idx_ready,
        output pix_ready, idx_valid, idx, idx_dist
    );

    modport master (
        output pix_valid, pix_rgb, idx_ready,
        input  pix_ready, idx_valid, idx, idx_dist
    );

endinterface

// File: rtl/rgb_l1_dist.sv
// rgb_l1_dist: combinational L1 distance between two {R,G,B} pixels.
//  i_a, i_b : pixels (PIX_W bits each)
//  o_dist   : |dR| + |dG| + |dB|, zero-extended to DIST_W (cannot overflow)
module rgb_l1_dist
    import vga_pkg::*;
(
    input  logic [PIX_W-1:0]  i_a,
    input  logic [PIX_W-1:0]  i_b,
    output logic [DIST_W-1:0] o_dist
);

    logic [CH_W-1:0] w_dr;
    logic [CH_W-1:0] w_dg;
    logic [CH_W-1:0] w_db;

    assign w_dr = ch_absdiff(i_a[3*CH_W-1:2*CH_W], i_b[3*CH_W-1:2*CH_W]);
    assign w_dg = ch_absdiff(i_a[2*CH_W-1:CH_W],   i_b[2*CH_W-1:CH_W]);
    assign w_db = ch_absdiff(i_a[CH_W-1:0],        i_b[CH_W-1:0]);

    assign o_dist = DIST_W'(w_dr) + DIST_W'(w_dg) + DIST_W'(w_db);

endmodule

// File: rtl/rgb_palette_encoder.sv
// rgb_palette_encoder: maps a 12-bit {R,G,B} pixel to the index of the
// nearest palette colour (L1 distance, lowest index wins a tie), scanning one
// palette entry per clock.
//  clk      : system clock, rising edge
//  rst      : asynchronous, active-high reset
//  bus      : rgb_palette_encoder_if.slave (pixel in, index/distance out)
//  o_state  : current FSM state, for observation
// Optional feature (macro RGB_ENC_EARLY_EXIT_EN): stop the scan at the first
// exact match (distance 0). Results are identical either way; only the
// latency changes.
module rgb_palette_encoder
    import vga_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rgb_palette_encoder_if.slave  bus,
    output enc_state_t            o_state
);

    localparam logic [IDX_W-1:0] K_LAST = '1;

    enc_state_t         r_state;
    enc_state_t         w_next_state;

    logic [IDX_W-1:0]   r_k;
    logic [PIX_W-1:0]   r_pix;
    logic [IDX_W-1:0]   r_best_idx;
    logic [DIST_W-1:0]  r_best_dist;
    logic [IDX_W-1:0]   r_idx;
    logic [DIST_W-1:0]  r_dist;

    logic               w_pix_ready;
    logic               w_accept;
    logic [DIST_W-1:0]  w_d;
    logic               w_better;
    logic [IDX_W-1:0]   w_cand_idx;
    logic [DIST_W-1:0]  w_cand_dist;
    logic               w_last;
    logic               w_exit;

    rgb_l1_dist u_dist (
        .i_a    (r_pix),
        .i_b    (PALETTE[r_k]),
        .o_dist (w_d)
    );

    // pix_ready is gated by rst so it reads 0 while reset is held even
    // though the FSM already sits in IDLE.
    assign w_pix_ready = (r_state == IDLE) && !rst;
    assign w_accept    = bus.pix_valid && w_pix_ready;

    // Strict compare: an equal distance later in the table never displaces
    // an earlier entry, so the lowest index wins ties.
    assign w_better    = (w_d < r_best_dist);
    assign w_cand_idx  = w_better ? r_k : r_best_idx;
    assign w_cand_dist = w_better ? w_d : r_best_dist;
    assign w_last      = (r_k == K_LAST);

`ifdef RGB_ENC_EARLY_EXIT_EN
    // Nothing can beat distance 0, and the first zero seen is the lowest
    // such index, so stopping here gives the same answer as a full scan.
    assign w_exit = w_last || (w_d == '0);
`else
    assign w_exit = w_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_next_state = SEARCH;
            SEARCH:  if (w_exit)        w_next_state = DONE;
            DONE:    if (bus.idx_ready) w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= '0;
            r_pix       <= '0;
            r_best_idx  <= '0;
            r_best_dist <= '1;
            r_idx       <= '0;
            r_dist      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pix       <= bus.pix_rgb;
                        r_k         <= '0;
                        r_best_idx  <= '0;
                        r_best_dist <= '1;
                    end
                end
                SEARCH: begin
                    r_best_idx  <= w_cand_idx;
                    r_best_dist <= w_cand_dist;
                    if (!w_last) begin
                        r_k <= r_k + 1'b1;
                    end
                    // The output registers include this cycle's compare so
                    // the result is ready the same edge DONE is entered.
                    if (w_exit) begin
                        r_idx  <= w_cand_idx;
                        r_dist <= w_cand_dist;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pix_ready = w_pix_ready;
    assign bus.idx_valid = (r_state == DONE);
    assign bus.idx       = r_idx;
    assign bus.idx_dist  = r_dist;
    assign o_state       = r_state;

endmodule

// File: tb/tb_rgb_palette_encoder.sv
// tb_rgb_palette_encoder: bench for rgb_palette_encoder. Reference model is a
// plain nearest-colour search over its own copy of the palette.
// Build with +define+RGB_ENC_EARLY_EXIT_EN to exercise the early-exit build.
module tb_rgb_palette_encoder;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    enc_state_t state;

    rgb_palette_encoder_if bus ();

    rgb_palette_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q [$];

    logic [11:0] ref_pal [16] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'h000,
        12'h888, 12'h800, 12'h080, 12'h008,
        12'hF80, 12'h8F0, 12'h08F, 12'h90F
    };

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Nearest palette entry by sum of absolute channel differences; first
    // (lowest) index kept on ties. Also the expected accept-to-valid edges.
    function automatic void model(input logic [11:0] p, output int bi,
                                  output int bd, output int lat);
        int d;
        bi = 0;
        bd = 1000;
        for (int k = 0; k < 16; k++) begin
            logic [11:0] c;
            c = ref_pal[k];
            d = iabs(int'(p[11:8]) - int'(c[11:8]))
              + iabs(int'(p[7:4])  - int'(c[7:4]))
              + iabs(int'(p[3:0])  - int'(c[3:0]));
            if (d < bd) begin
                bd = d;
                bi = k;
            end
        end
`ifdef RGB_ENC_EARLY_EXIT_EN
        lat = (bd == 0) ? bi + 1 : 16;
`else
        lat = 16;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a pixel in IDLE, waits for idx_valid, checks latency and
    // result. Leaves the DUT in DONE (handshake is up to the caller).
    task automatic run_pixel(input logic [11:0] p, input string name,
                             input bit noisy);
        int bi, bd, lat, n;
        logic [9:0] e;
        model(p, bi, bd, lat);
        exp_q.push_back({4'(bi), 6'(bd)});
        n_tests++;
        if (bus.pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s pix_ready before accept got %b want 1", name, bus.pix_ready);
        end
        bus.pix_valid = 1'b1;
        bus.pix_rgb   = p;
        tick();
        bus.pix_valid = 1'b0;
        n = 0;
        while (bus.idx_valid !== 1'b1 && n < 100) begin
            if (noisy) begin
                bus.pix_valid = 1'($urandom_range(0, 1));
                bus.pix_rgb   = 12'($urandom);
                n_tests++;
                if (bus.pix_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s pix_ready in search got %b want 0", name, bus.pix_ready);
                end
            end
            tick();
            n++;
        end
        bus.pix_valid = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if (n != lat) begin
            n_fail++;
            $display("FAIL %s latency got %0d edges want %0d (pix %h)", name, n, lat, p);
        end
        n_tests++;
        if (bus.idx !== e[9:6] || bus.idx_dist !== e[5:0]) begin
            n_fail++;
            $display("FAIL %s result pix %h got idx %0d dist %0d want idx %0d dist %0d",
                     name, p, bus.idx, bus.idx_dist, e[9:6], e[5:0]);
        end
    endtask

    task automatic finish_handshake(input string name);
        bus.idx_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.idx_valid !== 1'b0 || state !== IDLE || bus.pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after handshake got valid %b state %0d ready %b want 0 IDLE 1",
                     name, bus.idx_valid, state, bus.pix_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_rgb   = '0;
        bus.idx_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.pix_ready !== 1'b0 || bus.idx_valid !== 1'b0 || bus.idx !== 4'd0 ||
            bus.idx_dist !== 6'd0 || state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_hold got ready %b valid %b idx %0d dist %0d state %0d want 0 0 0 0 IDLE",
                     bus.pix_ready, bus.idx_valid, bus.idx, bus.idx_dist, state);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.pix_ready !== 1'b1 || bus.idx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got ready %b valid %b want 1 0", bus.pix_ready, bus.idx_valid);
        end
    endtask

    // Fixed pixel with an independently known answer (exact palette colour).
    task automatic test_known(input logic [11:0] p, input int want_idx, input string name);
        bus.idx_ready = 1'b1;
        run_pixel(p, name, 1'b0);
        n_tests++;
        if (bus.idx !== 4'(want_idx) || bus.idx_dist !== 6'd0) begin
            n_fail++;
            $display("FAIL %s known got idx %0d dist %0d want idx %0d dist 0",
                     name, bus.idx, bus.idx_dist, want_idx);
        end
        finish_handshake(name);
    endtask

    task automatic test_hold();
        bus.idx_ready = 1'b0;
        run_pixel(12'hF00, "hold", 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (bus.idx_valid !== 1'b1 || bus.idx !== 4'd0 || bus.idx_dist !== 6'd0 ||
                bus.pix_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d got valid %b idx %0d dist %0d ready %b want 1 0 0 0",
                         i, bus.idx_valid, bus.idx, bus.idx_dist, bus.pix_ready);
            end
        end
        finish_handshake("hold");
    endtask

    task automatic test_reset_mid();
        test_known(12'h90F, 15, "pre_rst");
        bus.pix_valid = 1'b1;
        bus.pix_rgb   = 12'h123;
        tick();
        bus.pix_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.idx_valid !== 1'b0 || bus.idx !== 4'd0 || bus.idx_dist !== 6'd0 ||
            state !== IDLE || bus.pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got valid %b idx %0d dist %0d state %0d ready %b want 0 0 0 IDLE 0",
                     bus.idx_valid, bus.idx, bus.idx_dist, state, bus.pix_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        test_known(12'h0FF, 4, "post_rst");
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int bi, bd, lat;
        model(12'h123, bi, bd, lat);
        bus.idx_ready = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_rgb   = 12'h123;
        for (int c = 0; c < 40; c++) begin
            if (bus.pix_ready === 1'b1) acc.push_back(c);
            tick();
        end
        bus.pix_valid = 1'b0;
        n_tests++;
        if (acc.size() < 2) begin
            n_fail++;
            $display("FAIL back_to_back accepts got %0d want >= 2", acc.size());
        end else if (acc[1] - acc[0] != lat + 2) begin
            n_fail++;
            $display("FAIL back_to_back spacing got %0d want %0d", acc[1] - acc[0], lat + 2);
        end
        for (int i = 0; i < 40 && state !== IDLE; i++) tick();
        n_tests++;
        if (state !== IDLE) begin
            n_fail++;
            $display("FAIL back_to_back drain got state %0d want IDLE", state);
        end
    endtask

    task automatic test_random();
        logic [11:0] p;
        logic [3:0]  hi;
        logic [5:0]  hd;
        bit          done;
        for (int t = 0; t < 1000; t++) begin
            bus.idx_ready = 1'($urandom_range(0, 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            if ($urandom_range(0, 3) == 0) p = ref_pal[$urandom_range(0, 15)];
            else                           p = 12'($urandom);
            run_pixel(p, "random", 1'b1);
            hi = bus.idx;
            hd = bus.idx_dist;
            done = 1'b0;
            for (int w = 0; w < 20 && !done; w++) begin
                bus.idx_ready = (w == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                done = bus.idx_ready;
                tick();
                if (!done) begin
                    n_tests++;
                    if (bus.idx_valid !== 1'b1 || bus.idx !== hi || bus.idx_dist !== hd) begin
                        n_fail++;
                        $display("FAIL random stall got valid %b idx %0d dist %0d want 1 %0d %0d",
                                 bus.idx_valid, bus.idx, bus.idx_dist, hi, hd);
                    end
                end
            end
            n_tests++;
            if (bus.idx_valid !== 1'b0 || state !== IDLE) begin
                n_fail++;
                $display("FAIL random release got valid %b state %0d want 0 IDLE",
                         bus.idx_valid, state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known(12'hF00, 0, "exact_f00");
        test_known(12'h90F, 15, "exact_90f");
        test_known(12'h0FF, 4, "exact_0ff");
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
